// File: rtl/serial_port_tx_pkg.sv
// Shared types for the serial port transmitter and router input port:
// field widths, FSM state encoding and the queued request format.
package serial_port_tx_pkg;

    localparam int unsigned ADDR_W    = 4;
    localparam int unsigned PAYLOAD_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        PAD,
        DATA,
        GAP
    } tx_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]    addr;
        logic [PAYLOAD_W-1:0] payload;
    } tx_req_t;

endpackage

// File: rtl/tx_req_queue.sv
// Synchronous request FIFO for the serial transmitter; push is dropped when
// full and pop is ignored when empty.
module tx_req_queue
    import serial_port_tx_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  tx_req_t                  push_data,
    input  logic                     pop,
    output tx_req_t                  pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    tx_req_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once count marks them valid.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/serial_port_tx.sv
// Host-side serializer: queues {addr, payload} requests and emits one
// frame_n/valid_n/di frame per request, LSB first, with registered outputs.
module serial_port_tx
    import serial_port_tx_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned PAD_CYCLES = 1,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [PAYLOAD_W-1:0] req_payload,
    output logic                 frame_n,
    output logic                 valid_n,
    output logic                 di,
    output logic                 busy,
    output logic [15:0]          frames_sent
);
    localparam int unsigned CNT_W     = $clog2(DEPTH) + 1;
    localparam logic [5:0]  ADDR_LAST = 6'(ADDR_W - 1);
    localparam logic [5:0]  DATA_LAST = 6'(PAYLOAD_W - 1);
    localparam logic [4:0]  PAD_LAST  = 5'(PAD_CYCLES - 1);
    localparam logic [4:0]  GAP_LAST  = 5'(GAP_CYCLES - 1);

    tx_state_e              state, state_nxt;
    logic [5:0]             bit_cnt, bit_cnt_nxt;
    logic [4:0]             pad_cnt, pad_cnt_nxt;
    logic [4:0]             gap_cnt, gap_cnt_nxt;
    logic [ADDR_W-1:0]      addr_sr;
    logic [PAYLOAD_W-1:0]   pay_sr;
    logic                   frame_n_d, valid_n_d, di_d;
    logic                   q_pop, shift_addr, shift_pay, frame_done;
    logic                   q_full, q_empty;
    logic [CNT_W-1:0]       q_count;
    tx_req_t                q_in, q_head;

    assign q_in      = '{addr: req_addr, payload: req_payload};
    assign req_ready = !q_full;
    assign busy      = (state != IDLE) || (q_count != '0);

    tx_req_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (req_valid),
        .push_data (q_in),
        .pop       (q_pop),
        .pop_data  (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    // Pin values are computed from the current state and registered, so the
    // pins trail the state by one cycle.
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        pad_cnt_nxt = pad_cnt;
        gap_cnt_nxt = gap_cnt;
        frame_n_d   = 1'b1;
        valid_n_d   = 1'b1;
        di_d        = 1'b0;
        q_pop       = 1'b0;
        shift_addr  = 1'b0;
        shift_pay   = 1'b0;
        frame_done  = 1'b0;
        case (state)
            IDLE: begin
                if (!q_empty) begin
                    q_pop       = 1'b1;
                    bit_cnt_nxt = '0;
                    state_nxt   = ADDR;
                end
            end
            ADDR: begin
                frame_n_d  = 1'b0;
                di_d       = addr_sr[0];
                shift_addr = 1'b1;
                if (bit_cnt == ADDR_LAST) begin
                    bit_cnt_nxt = '0;
                    pad_cnt_nxt = '0;
                    state_nxt   = (PAD_CYCLES == 0) ? DATA : PAD;
                end else begin
                    bit_cnt_nxt = bit_cnt + 6'd1;
                end
            end
            PAD: begin
                frame_n_d = 1'b0;
                if (pad_cnt == PAD_LAST) state_nxt = DATA;
                else                     pad_cnt_nxt = pad_cnt + 5'd1;
            end
            DATA: begin
                valid_n_d = 1'b0;
                di_d      = pay_sr[0];
                shift_pay = 1'b1;
                frame_n_d = (bit_cnt == DATA_LAST);
                if (bit_cnt == DATA_LAST) begin
                    frame_done  = 1'b1;
                    gap_cnt_nxt = '0;
                    state_nxt   = GAP;
                end else begin
                    bit_cnt_nxt = bit_cnt + 6'd1;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    if (!q_empty) begin
                        q_pop       = 1'b1;
                        bit_cnt_nxt = '0;
                        state_nxt   = ADDR;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    gap_cnt_nxt = gap_cnt + 5'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            pad_cnt     <= '0;
            gap_cnt     <= '0;
            addr_sr     <= '0;
            pay_sr      <= '0;
            frame_n     <= 1'b1;
            valid_n     <= 1'b1;
            di          <= 1'b0;
            frames_sent <= '0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            pad_cnt <= pad_cnt_nxt;
            gap_cnt <= gap_cnt_nxt;
            frame_n <= frame_n_d;
            valid_n <= valid_n_d;
            di      <= di_d;
            if (q_pop) begin
                addr_sr <= q_head.addr;
                pay_sr  <= q_head.payload;
            end else begin
                if (shift_addr) addr_sr <= addr_sr >> 1;
                if (shift_pay)  pay_sr  <= pay_sr >> 1;
            end
            if (frame_done) frames_sent <= frames_sent + 16'd1;
        end
    end

endmodule
